pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush controller for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: decode/execute/memory hazard inputs plus stall/flush/status outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             idRs1;
  logic [4:0]             idRs2;
  logic                   idUsesRs1;
  logic                   idUsesRs2;
  logic [4:0]             exRd;
  logic [1:0]             exMemOp;
  logic [1:0]             memOp;
  logic                   dmemReady;
  logic                   branchTaken;
  logic                   dmemReq;
  logic                   pcStall;
  logic                   ifidStall;
  logic                   idexStall;
  logic                   exmemStall;
  logic                   ifidFlush;
  logic                   idexFlush;
  logic                   memwbFlush;
  logic                   fault;
  logic [STALL_CNT_W-1:0] stallCycles;

  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemOp, memOp, dmemReady, branchTaken,
    input  dmemReq, pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush, memwbFlush,
    input  fault, stallCycles
  );

  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemOp, memOp, dmemReady, branchTaken,
    output dmemReq, pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush, memwbFlush,
    output fault, stallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: data-memory wait with timeout fault, branch squash, load-use bubble.
// Stall/flush/dmemReq are combinational (0-cycle); fault and stallCycles are registered.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_fault;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic w_mem_valid;
  logic w_dmem_req;
  logic w_mem_stall;
  logic w_load_use;
  logic w_pc_stall;
  logic w_ifid_stall;
  logic w_idex_stall;
  logic w_exmem_stall;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_memwb_flush;

  assign w_mem_valid = (bus.memOp == 2'b01) || (bus.memOp == 2'b10);
  assign w_dmem_req  = w_mem_valid && (r_state != ST_FAULT) && !reset;
  assign w_mem_stall = w_dmem_req && !bus.dmemReady;
  assign w_load_use  = (bus.exMemOp == 2'b01) && (bus.exRd != 5'd0) &&
                       ((bus.idUsesRs1 && (bus.idRs1 == bus.exRd)) ||
                        (bus.idUsesRs2 && (bus.idRs2 == bus.exRd)));

  // Memory stall outranks branch squash, which outranks the load-use bubble.
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_stall  = 1'b0;
    w_exmem_stall = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_memwb_flush = 1'b0;
    if (!reset) begin
      if (r_state == ST_FAULT) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
      end else if (w_mem_stall) begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
        w_memwb_flush = 1'b1;
      end else if (bus.branchTaken) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_fault        <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != {STALL_CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          // Ready on the last allowed cycle still completes; a dropped request also releases the wait.
          if (!w_mem_stall) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_FAULT: r_fault <= 1'b1;
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.dmemReq     = w_dmem_req;
  assign bus.pcStall     = w_pc_stall;
  assign bus.ifidStall   = w_ifid_stall;
  assign bus.idexStall   = w_idex_stall;
  assign bus.exmemStall  = w_exmem_stall;
  assign bus.ifidFlush   = w_ifid_flush;
  assign bus.idexFlush   = w_idex_flush;
  assign bus.memwbFlush  = w_memwb_flush;
  assign bus.fault       = r_fault;
  assign bus.stallCycles = r_stall_cycles;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default and small timeout/counter) share one stimulus stream.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(32)) ifa ();
  pipeline_hazard_ctrl_if #(.STALL_CNT_W(3))  ifb ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .STALL_CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4),  .STALL_CNT_W(3))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

  typedef struct packed {
    logic       rst;
    logic [1:0] mem_op;
    logic [1:0] ex_mem_op;
    logic [4:0] ex_rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rdy;
    logic       br;
  } stim_t;

  stim_t cur;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference state: fault flag, consecutive stalled-access cycles, saturating stall count.
  int    tmo[2]  = '{16, 4};
  longint cmax[2] = '{64'h0000_0000_FFFF_FFFF, 64'd7};
  bit    m_fault[2];
  int    m_wait[2];
  longint m_cnt[2];
  bit    m_known = 1'b0;

  function automatic bit ref_mem_stall(int d);
    return !cur.rst && !m_fault[d] && (cur.mem_op == 2'b01 || cur.mem_op == 2'b10) && !cur.rdy;
  endfunction

  // {dmemReq, pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush, memwbFlush}
  function automatic logic [7:0] ref_out(int d);
    bit valid;
    bit lu;
    if (cur.rst) return 8'h00;
    if (m_fault[d]) return 8'b0_1111_000;
    valid = (cur.mem_op == 2'b01 || cur.mem_op == 2'b10);
    lu = (cur.ex_mem_op == 2'b01) && (cur.ex_rd != 0) &&
         ((cur.u1 && cur.rs1 == cur.ex_rd) || (cur.u2 && cur.rs2 == cur.ex_rd));
    if (ref_mem_stall(d)) return 8'b1_1111_001;
    if (cur.br) return {valid, 7'b0000_110};
    if (lu) return {valid, 7'b1100_010};
    return {valid, 7'b0};
  endfunction

  task automatic ref_advance(int d, logic [7:0] o);
    if (cur.rst) begin
      m_fault[d] = 1'b0;
      m_wait[d]  = 0;
      m_cnt[d]   = 0;
      return;
    end
    if (o[6] && m_cnt[d] < cmax[d]) m_cnt[d]++;
    if (ref_mem_stall(d)) begin
      m_wait[d]++;
      if (m_wait[d] == tmo[d]) m_fault[d] = 1'b1;
    end else begin
      m_wait[d] = 0;
    end
  endtask

  function automatic logic [7:0] obs_out(int d);
    if (d == 0)
      return {ifa.dmemReq, ifa.pcStall, ifa.ifidStall, ifa.idexStall, ifa.exmemStall,
              ifa.ifidFlush, ifa.idexFlush, ifa.memwbFlush};
    return {ifb.dmemReq, ifb.pcStall, ifb.ifidStall, ifb.idexStall, ifb.exmemStall,
            ifb.ifidFlush, ifb.idexFlush, ifb.memwbFlush};
  endfunction

  function automatic logic [63:0] obs_cnt(int d);
    return (d == 0) ? 64'(ifa.stallCycles) : 64'(ifb.stallCycles);
  endfunction

  function automatic logic obs_fault(int d);
    return (d == 0) ? ifa.fault : ifb.fault;
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic drive();
    reset           = cur.rst;
    ifa.memOp       = cur.mem_op;    ifb.memOp       = cur.mem_op;
    ifa.exMemOp     = cur.ex_mem_op; ifb.exMemOp     = cur.ex_mem_op;
    ifa.exRd        = cur.ex_rd;     ifb.exRd        = cur.ex_rd;
    ifa.idRs1       = cur.rs1;       ifb.idRs1       = cur.rs1;
    ifa.idRs2       = cur.rs2;       ifb.idRs2       = cur.rs2;
    ifa.idUsesRs1   = cur.u1;        ifb.idUsesRs1   = cur.u1;
    ifa.idUsesRs2   = cur.u2;        ifb.idUsesRs2   = cur.u2;
    ifa.dmemReady   = cur.rdy;       ifb.dmemReady   = cur.rdy;
    ifa.branchTaken = cur.br;        ifb.branchTaken = cur.br;
  endtask

  // One cycle: drive after the falling edge, check 1 time unit later, then advance the model.
  task automatic step(input string tag);
    logic [7:0] e;
    @(negedge clk);
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      e = ref_out(d);
      chk({tag, "_out"}, d, 64'(obs_out(d)), 64'(e));
      if (m_known) begin
        chk({tag, "_fault"}, d, 64'(obs_fault(d)), 64'(m_fault[d]));
        chk({tag, "_cnt"}, d, obs_cnt(d), 64'(m_cnt[d]));
      end
      ref_advance(d, e);
    end
    if (cur.rst) m_known = 1'b1;
  endtask

  initial begin
    cur = '0;
    cur.rst = 1'b1;
    drive();
    step("rst");
    step("rst");
    cur.rst = 1'b0;
    step("idle");
    chk("rst_cnt", 0, obs_cnt(0), 64'd0);
    chk("rst_fault", 1, 64'(obs_fault(1)), 64'd0);

    // Load answered in the same cycle: request, no stall.
    cur.mem_op = 2'b01; cur.rdy = 1'b1;
    step("t1");
    chk("t1_req", 0, 64'(ifa.dmemReq), 64'd1);
    chk("t1_pcstall", 0, 64'(ifa.pcStall), 64'd0);
    cur = '0;
    step("t1_idle");
    chk("t1_cnt", 0, obs_cnt(0), 64'd0);

    // Store answered after 3 wait cycles.
    cur.mem_op = 2'b10; cur.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("t2_wait");
      chk("t2_memwb", 0, 64'(ifa.memwbFlush), 64'd1);
    end
    cur.rdy = 1'b1;
    step("t2_done");
    chk("t2_done_stall", 0, 64'(ifa.exmemStall), 64'd0);
    cur = '0;
    step("t2_idle");
    chk("t2_cnt", 0, obs_cnt(0), 64'd3);
    chk("t2_cnt", 1, obs_cnt(1), 64'd3);

    // Load-use on rs2, then the same with exRd=0.
    cur.ex_mem_op = 2'b01; cur.ex_rd = 5'd5; cur.rs2 = 5'd5; cur.u2 = 1'b1;
    step("t3_lu");
    chk("t3_pcstall", 0, 64'(ifa.pcStall), 64'd1);
    chk("t3_idexflush", 0, 64'(ifa.idexFlush), 64'd1);
    cur.ex_rd = 5'd0; cur.rs2 = 5'd0;
    step("t3_x0");
    chk("t3_x0_pcstall", 0, 64'(ifa.pcStall), 64'd0);

    // Branch beats load-use; memory stall beats both.
    cur.ex_rd = 5'd7; cur.rs2 = 5'd7; cur.br = 1'b1;
    step("t4_br");
    chk("t4_ifidflush", 0, 64'(ifa.ifidFlush), 64'd1);
    chk("t4_pcstall", 0, 64'(ifa.pcStall), 64'd0);
    cur.mem_op = 2'b01; cur.rdy = 1'b0;
    step("t4_mem");
    chk("t4_mem_exmem", 0, 64'(ifa.exmemStall), 64'd1);
    chk("t4_mem_ifidflush", 0, 64'(ifa.ifidFlush), 64'd0);
    cur.rdy = 1'b1;
    step("t4_rel");
    cur = '0;
    step("t4_idle");

    // Memory never answers: small-timeout instance faults, reset clears it.
    cur.rst = 1'b1; step("t5_rst"); cur.rst = 1'b0;
    cur.mem_op = 2'b01; cur.rdy = 1'b0;
    for (int i = 0; i < 6; i++) step("t5_hang");
    chk("t5_fault", 1, 64'(ifb.fault), 64'd1);
    chk("t5_req", 1, 64'(ifb.dmemReq), 64'd0);
    chk("t5_nofault", 0, 64'(ifa.fault), 64'd0);
    cur.rst = 1'b1; step("t5_rst2"); cur.rst = 1'b0;
    step("t5_after");
    chk("t5_clr_fault", 1, 64'(ifb.fault), 64'd0);
    chk("t5_clr_cnt", 1, obs_cnt(1), 64'd0);

    // Ten stalled cycles: 3-bit counter saturates at 7.
    cur.rst = 1'b1; step("t6_rst"); cur.rst = 1'b0;
    cur.mem_op = 2'b01; cur.rdy = 1'b0;
    for (int i = 0; i < 10; i++) step("t6_hang");
    cur = '0;
    step("t6_idle");
    chk("t6_sat", 1, obs_cnt(1), 64'd7);
    chk("t6_cnt", 0, obs_cnt(0), 64'd10);
    cur.rst = 1'b1; step("t6_rst2");

    // Randomized traffic: first phase responsive memory, second phase slow memory.
    for (int i = 0; i < 1200; i++) begin
      cur.rst       = ($urandom_range(0, 59) == 0);
      cur.mem_op    = 2'($urandom_range(0, 3));
      cur.ex_mem_op = 2'($urandom_range(0, 3));
      cur.ex_rd     = 5'($urandom_range(0, 3));
      cur.rs1       = 5'($urandom_range(0, 3));
      cur.rs2       = 5'($urandom_range(0, 3));
      cur.u1        = 1'($urandom_range(0, 1));
      cur.u2        = 1'($urandom_range(0, 1));
      cur.br        = ($urandom_range(0, 7) == 0);
      cur.rdy       = (i < 600) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      if (i >= 600 && cur.mem_op != 2'b00 && cur.mem_op != 2'b11 && $urandom_range(0, 1) == 0)
        cur.mem_op = 2'b10;
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
